float_addsub_lanes: RTL and testbench

- Multi-lane, fixed-latency IEEE-754 single-precision add/subtract unit with a per-beat operation mode and a tag passthrough.
- Adds valid/ready backpressure on both sides. A credit counter and an output FIFO absorb the non-stallable float core pipeline.
- Sits in the compute datapath between operand fetch and the accumulator/writeback stages. It replaces single-lane subtract instances wherever ready-based flow control is needed.

---
 rtl/float_addsub_lanes.sv | 231 +++++++++++++++++++++++
 tb/tb_float_addsub_lanes.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/float_addsub_lanes.sv
// Multi-lane IEEE-754 single-precision add/subtract with credit-based valid/ready flow control.
// Optional FLOAT_ADDSUB_EXC_EN adds per-lane {NaN, Inf} flags (out_exc) and a sticky OR (exc_sticky).
module float_addsub_lanes #(
  parameter int N_LANES     = 4,
  parameter int ADD_LATENCY = 3,
  parameter int FIFO_DEPTH  = 8,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [32*N_LANES-1:0]  in_a,
  input  logic [32*N_LANES-1:0]  in_b,
  input  logic [1:0]             in_op,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [32*N_LANES-1:0]  out_q,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef FLOAT_ADDSUB_EXC_EN
  ,
  output logic [2*N_LANES-1:0]   out_exc,
  output logic [2*N_LANES-1:0]   exc_sticky
`endif
);

  localparam int DW  = 32 * N_LANES;
`ifdef FLOAT_ADDSUB_EXC_EN
  localparam int FW  = DW + TAG_WIDTH + 2 * N_LANES;
`else
  localparam int FW  = DW + TAG_WIDTH;
`endif
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CW1 = CW + 1;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_RSUB = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  // Single-precision add, round-to-nearest-even, denormal inputs/outputs flushed to zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic        sx, sy;
    logic [7:0]  ex, ey, d;
    logic [26:0] mx, my, mys, norm;
    logic [27:0] sum;
    logic [24:0] rnd;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, inc, found;
    int          e, lz;
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if (a_inf && b_inf) return (a[31] != b[31]) ? 32'h7FC0_0000 : a;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
    if (b_zero) return a;
    if (a_zero) return b;
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    sx = x[31]; sy = y[31];
    ex = x[30:23]; ey = y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    d  = ex - ey;
    if (d > 8'd26) begin
      mys = 27'd1;
    end else begin
      mys = my >> d;
      if ((my & ((27'd1 << d) - 27'd1)) != 27'd0) mys[0] = 1'b1;
    end
    e = int'(ex);
    if (sx == sy) begin
      sum = {1'b0, mx} + {1'b0, mys};
      if (sum[27]) begin
        norm = {sum[27:2], sum[1] | sum[0]};
        e    = e + 1;
      end else begin
        norm = sum[26:0];
      end
    end else begin
      norm = mx - mys;
      if (norm == 27'd0) return 32'd0;
      lz    = 0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (norm[i]) found = 1'b1;
          else         lz    = lz + 1;
        end
      end
      norm = norm << lz;
      e    = e - lz;
    end
    if (e <= 0) return {sx, 31'd0};
    inc = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd = {1'b0, norm[26:3]} + {24'd0, inc};
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 1;
    end
    if (e >= 255) return {sx, 8'hFF, 23'd0};
    return {sx, e[7:0], rnd[22:0]};
  endfunction

  logic                 accept, push, pop, load;
  logic                 out_valid_next, ready_next;
  logic [CW-1:0]        mem_count, mem_count_next, inflight, inflight_next, fifo_count_next;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [DW-1:0]        res_comb;
  logic [DW-1:0]        pipe_q   [ADD_LATENCY];
  logic [TAG_WIDTH-1:0] pipe_tag [ADD_LATENCY];
  logic [ADD_LATENCY-1:0] pipe_v;
  logic [FW-1:0]        mem [FIFO_DEPTH];
  logic [FW-1:0]        wr_entry, out_entry;

  // Operand preprocessing: sign flips for subtraction, -0 addend for bit-exact passthrough.
  always_comb begin
    logic [31:0] la, lb;
    res_comb = '0;
    for (int i = 0; i < N_LANES; i++) begin
      la = in_a[32*i +: 32];
      lb = in_b[32*i +: 32];
      case (op_e'(in_op))
        OP_SUB:  lb[31] = ~lb[31];
        OP_RSUB: la[31] = ~la[31];
        OP_PASS: lb     = 32'h8000_0000;
        default: ;
      endcase
      res_comb[32*i +: 32] = fp_add(la, lb);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= accept;
      for (int s = 1; s < ADD_LATENCY; s++) pipe_v[s] <= pipe_v[s-1];
    end
  end

  // NOTE: datapath registers and FIFO storage carry no reset; only the valids that qualify them do.
  always_ff @(posedge clk) begin
    pipe_q[0]   <= res_comb;
    pipe_tag[0] <= in_tag;
    for (int s = 1; s < ADD_LATENCY; s++) begin
      pipe_q[s]   <= pipe_q[s-1];
      pipe_tag[s] <= pipe_tag[s-1];
    end
  end

`ifdef FLOAT_ADDSUB_EXC_EN
  logic [2*N_LANES-1:0] tail_exc;
  always_comb begin
    logic [31:0] r;
    tail_exc = '0;
    for (int i = 0; i < N_LANES; i++) begin
      r = pipe_q[ADD_LATENCY-1][32*i +: 32];
      tail_exc[2*i+1] = (r[30:23] == 8'hFF) && (r[22:0] != 23'd0);
      tail_exc[2*i]   = (r[30:23] == 8'hFF) && (r[22:0] == 23'd0);
    end
  end
  assign wr_entry = {tail_exc, pipe_tag[ADD_LATENCY-1], pipe_q[ADD_LATENCY-1]};
  assign out_exc  = out_entry[DW+TAG_WIDTH +: 2*N_LANES];
`else
  assign wr_entry = {pipe_tag[ADD_LATENCY-1], pipe_q[ADD_LATENCY-1]};
`endif

  assign out_q   = out_entry[DW-1:0];
  assign out_tag = out_entry[DW +: TAG_WIDTH];

  // Credit accounting: storage counts the output register too, so FIFO_DEPTH bounds everything held.
  always_comb begin
    accept          = in_valid && in_ready;
    push            = pipe_v[ADD_LATENCY-1];
    pop             = out_valid && out_ready;
    load            = (mem_count != '0) && (!out_valid || pop);
    mem_count_next  = mem_count + CW'(push) - CW'(load);
    out_valid_next  = load || (out_valid && !pop);
    inflight_next   = inflight + CW'(accept) - CW'(push);
    fifo_count_next = mem_count_next + CW'(out_valid_next);
    ready_next      = ({1'b0, fifo_count_next} + {1'b0, inflight_next}) < CW1'(FIFO_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      inflight  <= '0;
      out_valid <= 1'b0;
      out_entry <= '0;
      in_ready  <= 1'b0;
    end else begin
      mem_count <= mem_count_next;
      inflight  <= inflight_next;
      out_valid <= out_valid_next;
      in_ready  <= ready_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (load) begin
        out_entry <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + PW'(1);
      end
    end
  end

`ifdef FLOAT_ADDSUB_EXC_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   exc_sticky <= '0;
    else if (pop) exc_sticky <= exc_sticky | out_exc;
  end
`endif

endmodule

// File: tb/tb_float_addsub_lanes.sv
// Directed bench for float_addsub_lanes: ops, latency, throughput, backpressure, reset, exception flags.
// Inputs change 1ns after the falling edge; the scoreboard monitor samples 3ns after it.
module tb_float_addsub_lanes;
  localparam int NL = 4;
  localparam int TW = 8;
  localparam int DW = 32 * NL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic [1:0]    in_op = 2'b00;
  logic [TW-1:0] in_tag = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_q;
  logic [TW-1:0] out_tag;
  logic          out_valid;
  logic          out_ready = 1'b1;
`ifdef FLOAT_ADDSUB_EXC_EN
  logic [2*NL-1:0] out_exc, exc_sticky;
`endif

  float_addsub_lanes #(.N_LANES(NL), .ADD_LATENCY(3), .FIFO_DEPTH(8), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(rst_n),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_q(out_q), .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready)
`ifdef FLOAT_ADDSUB_EXC_EN
    , .out_exc(out_exc), .exc_sticky(exc_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0]   tag;
    logic [DW-1:0]   q;
    logic [2*NL-1:0] exc;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   run_len = 0;
  int   max_run = 0;
  localparam logic [DW-1:0] JUNK_B = {NL{32'h1234_5678}};

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pt_vec(input logic [7:0] t);
    logic [DW-1:0] v;
    for (int i = 0; i < NL; i++) v[32*i +: 32] = 32'h3F80_0000 | {16'd0, t, 8'd0} | 32'(i);
    return v;
  endfunction

  task automatic push_exp(input logic [TW-1:0] tag, input logic [DW-1:0] q, input logic [2*NL-1:0] exc);
    exp_t e;
    e.tag = tag; e.q = q; e.exc = exc;
    sb.push_back(e);
  endtask

  // Offer one beat and hold it until accepted; leaves in_valid high for back-to-back use.
  task automatic offer(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] tag, input logic [DW-1:0] q, input logic [2*NL-1:0] exc);
    int w = 0;
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    check("accept_wait", DW'(w < 100), DW'(1));
    push_exp(tag, q, exc);
    tick();
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 300) begin
      tick();
      w++;
    end
    check("drain_empty", DW'(sb.size()), DW'(0));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    #3;
    if (out_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (out_valid && out_ready) begin
      check("pop_expected", DW'(sb.size() != 0), DW'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_tag", DW'(out_tag), DW'(e.tag));
        check("out_q", out_q, e.q);
`ifdef FLOAT_ADDSUB_EXC_EN
        check("out_exc", DW'(out_exc), DW'(e.exc));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, t, lat;
    repeat (2) tick();
    check("rst_in_ready", DW'(in_ready), DW'(0));
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_q", out_q, DW'(0));
    check("rst_out_tag", DW'(out_tag), DW'(0));
    rst_n = 1'b1;
    tick();
    check("in_ready_after_rst", DW'(in_ready), DW'(1));

    // Basic ops on 3.0 and 1.0
    offer(2'b00, {NL{32'h4040_0000}}, {NL{32'h3F80_0000}}, 8'd1, {NL{32'h4080_0000}}, '0);
    offer(2'b01, {NL{32'h4040_0000}}, {NL{32'h3F80_0000}}, 8'd2, {NL{32'h4000_0000}}, '0);
    offer(2'b10, {NL{32'h4040_0000}}, {NL{32'h3F80_0000}}, 8'd3, {NL{32'hC000_0000}}, '0);
    offer(2'b11, {NL{32'h4040_0000}}, {NL{32'h3F80_0000}}, 8'd4, {NL{32'h4040_0000}}, '0);
    in_valid = 1'b0;
    drain();

    // Passthrough of +0 must stay +0
    offer(2'b11, '0, JUNK_B, 8'd6, '0, '0);
    in_valid = 1'b0;
    drain();

    // Single-beat latency
    offer(2'b11, pt_vec(8'd5), JUNK_B, 8'd5, pt_vec(8'd5), '0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", DW'(lat), DW'(4));
    drain();

    // Back-to-back throughput
    max_run = 0;
    for (int k = 16; k < 32; k++) offer(2'b11, pt_vec(8'(k)), JUNK_B, 8'(k), pt_vec(8'(k)), '0);
    in_valid = 1'b0;
    drain();
    check("b2b_run", DW'(max_run), DW'(16));

    // Backpressure: fill credits, one pop, exactly one further accept
    acc = 0;
    t = 100;
    for (int i = 0; i < 40; i++) begin
      in_op = 2'b11; in_a = pt_vec(8'(t)); in_b = JUNK_B; in_tag = 8'(t); in_valid = 1'b1;
      out_ready = (i == 20);
      if (i == 20) begin
        check("bp_accepted_8", DW'(acc), DW'(8));
        check("bp_in_ready_low", DW'(in_ready), DW'(0));
      end
      if (in_ready) begin
        push_exp(8'(t), pt_vec(8'(t)), '0);
        acc++;
        t++;
      end
      tick();
    end
    check("bp_accepted_9", DW'(acc), DW'(9));

    // Full FIFO with pops and tail writes interleaved
    for (int i = 0; i < 60; i++) begin
      in_op = 2'b11; in_a = pt_vec(8'(t)); in_b = JUNK_B; in_tag = 8'(t); in_valid = 1'b1;
      out_ready = (i % 3 != 0);
      if (in_ready) begin
        push_exp(8'(t), pt_vec(8'(t)), '0);
        t++;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with 3 beats in the pipeline and 2 in the FIFO
    out_ready = 1'b0;
    for (int k = 200; k < 205; k++) offer(2'b11, pt_vec(8'(k)), JUNK_B, 8'(k), pt_vec(8'(k)), '0);
    in_valid = 1'b0;
    check("pre_rst_out_valid", DW'(out_valid), DW'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", DW'(out_valid), DW'(0));
    check("midrst_in_ready", DW'(in_ready), DW'(0));
    check("midrst_out_q", out_q, DW'(0));
    check("midrst_out_tag", DW'(out_tag), DW'(0));
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("in_ready_after_midrst", DW'(in_ready), DW'(1));
    repeat (20) tick();
    check("no_stale_valid", DW'(out_valid), DW'(0));
    offer(2'b00, {NL{32'h4040_0000}}, {NL{32'h3F80_0000}}, 8'd42, {NL{32'h4080_0000}}, '0);
    in_valid = 1'b0;
    drain();

`ifdef FLOAT_ADDSUB_EXC_EN
    offer(2'b01, {NL{32'h7F80_0000}}, {NL{32'h7F80_0000}}, 8'd60, {NL{32'h7FC0_0000}}, {NL{2'b10}});
    offer(2'b00, {NL{32'h7F7F_FFFF}}, {NL{32'h7F7F_FFFF}}, 8'd61, {NL{32'h7F80_0000}}, {NL{2'b01}});
    in_valid = 1'b0;
    drain();
    check("exc_sticky", DW'(exc_sticky), DW'({NL{2'b11}}));
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
